// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and FSM encoding shared by the PWM generator and capture blocks.
package pwm_pkg;

    localparam int PWM_WIDTH   = 10;
    localparam int PWM_TIMEOUT = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input and measurement results of the capture block.
// master = the side driving pwm_in, slave = the capture block itself.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) ();

    logic             pwm_in;
    logic [WIDTH-1:0] duty_out;
    logic [WIDTH-1:0] period_out;
    logic             duty_vld;
    logic             stuck;
    logic             stuck_lvl;

    modport master (
        output pwm_in,
        input  duty_out,
        input  period_out,
        input  duty_vld,
        input  stuck,
        input  stuck_lvl
    );

    modport slave (
        input  pwm_in,
        output duty_out,
        output period_out,
        output duty_vld,
        output stuck,
        output stuck_lvl
    );

endinterface

// File: rtl/pwm_sync_filt.sv
// pwm_sync_filt: synchronizes the asynchronous PWM input, optionally filters
// glitches, and produces one-cycle rise/fall pulses.
// Optional feature macro: PWM_CAPTURE_FILTER_EN. When defined, the level only
// changes after 3 identical consecutive samples (both edges delayed by 2 cycles).
module pwm_sync_filt #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   raw_s;
    logic                   pwm_d_r;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign raw_s = sync_r[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;
    logic       filt_s;

    // Accept a new level only when the current and two previous samples agree.
    always_comb begin
        filt_s = filt_r;
        if ((raw_s == hist_r[0]) && (raw_s == hist_r[1])) begin
            filt_s = raw_s;
        end else begin
            filt_s = filt_r;
        end
    end

    // Keep the two-sample history and the last accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= 2'b00;
            filt_r <= 1'b0;
        end else begin
            hist_r <= {hist_r[0], raw_s};
            filt_r <= filt_s;
        end
    end

    assign pwm_s = filt_s;
`else
    assign pwm_s = raw_s;
`endif

    // Delayed copy of the level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_d_r <= 1'b0;
        end else begin
            pwm_d_r <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d_r;
    assign fall = ~pwm_s & pwm_d_r;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// clk cycles and reports them as (count - 1), the same encoding pwm_gen uses.
// A missing edge for TIMEOUT cycles flags the input as stuck.
// Optional feature macro: PWM_CAPTURE_FILTER_EN (glitch filter in pwm_sync_filt).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);

    localparam int              CW        = WIDTH + 2;
    localparam int              IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   IDLE_FULL = IW'(TIMEOUT);
    localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic          pwm_s;
    logic          rise_s;
    logic          fall_s;
    logic          edge_s;
    logic          timeout_s;
    logic          latch_s;
    pwm_state_e    state_r;
    pwm_state_e    state_nxt_s;
    logic [CW-1:0] hi_cnt_r;
    logic [CW-1:0] per_cnt_r;
    logic [IW-1:0] idle_cnt_r;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Count minus one, clamped to the output range.
    function automatic logic [WIDTH-1:0] clamp_dec(input logic [CW-1:0] v);
        logic [CW-1:0]    d;
        logic [WIDTH-1:0] r;
        if (v == {CW{1'b0}}) begin
            d = {CW{1'b0}};
        end else begin
            d = v - CNT_ONE;
        end
        if (d[CW-1:WIDTH] != {(CW-WIDTH){1'b0}}) begin
            r = {WIDTH{1'b1}};
        end else begin
            r = d[WIDTH-1:0];
        end
        return r;
    endfunction

    pwm_sync_filt #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (bus.pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // An edge on the same cycle as the timeout wins, so no stuck is raised.
    assign edge_s    = rise_s | fall_s;
    assign timeout_s = ~edge_s & ~bus.stuck & (idle_cnt_r == IDLE_LAST);
    assign latch_s   = (state_r == LOW) & rise_s;

    // Next-state logic: a timeout always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (rise_s) state_nxt_s = HIGH; else state_nxt_s = IDLE;
                HIGH:    if (fall_s) state_nxt_s = LOW;  else state_nxt_s = HIGH;
                LOW:     if (rise_s) state_nxt_s = HIGH; else state_nxt_s = LOW;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // High-time and period counters; the rise cycle is cycle 1 of a new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_r  <= {CW{1'b0}};
            per_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE, LOW: begin
                    if (rise_s) begin
                        hi_cnt_r  <= CNT_ONE;
                        per_cnt_r <= CNT_ONE;
                    end else begin
                        hi_cnt_r  <= hi_cnt_r;
                        per_cnt_r <= (state_r == LOW) ? sat_inc(per_cnt_r) : per_cnt_r;
                    end
                end
                HIGH: begin
                    per_cnt_r <= sat_inc(per_cnt_r);
                    hi_cnt_r  <= fall_s ? hi_cnt_r : sat_inc(hi_cnt_r);
                end
                default: begin
                    hi_cnt_r  <= {CW{1'b0}};
                    per_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Cycles since the last edge; parks at TIMEOUT while stuck.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (edge_s) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (timeout_s || bus.stuck) begin
            idle_cnt_r <= IDLE_FULL;
        end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
        end
    end

    // Measurement outputs, valid pulse and stuck reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.duty_out   <= {WIDTH{1'b0}};
            bus.period_out <= {WIDTH{1'b0}};
            bus.duty_vld   <= 1'b0;
            bus.stuck      <= 1'b0;
            bus.stuck_lvl  <= 1'b0;
        end else if (timeout_s) begin
            bus.duty_out   <= pwm_s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            bus.period_out <= {WIDTH{1'b1}};
            bus.duty_vld   <= 1'b1;
            bus.stuck      <= 1'b1;
            bus.stuck_lvl  <= pwm_s;
        end else begin
            bus.duty_vld <= latch_s;
            if (latch_s) begin
                bus.duty_out   <= clamp_dec(hi_cnt_r);
                bus.period_out <= clamp_dec(per_cnt_r);
            end else begin
                bus.duty_out   <= bus.duty_out;
                bus.period_out <= bus.period_out;
            end
            if (edge_s) begin
                bus.stuck     <= 1'b0;
                bus.stuck_lvl <= 1'b0;
            end else begin
                bus.stuck     <= bus.stuck;
                bus.stuck_lvl <= bus.stuck_lvl;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture. A small in-bench generator
// drives duty D as D+1 high cycles per period (pwm_gen encoding).
// Honors PWM_CAPTURE_FILTER_EN: short 1-cycle pulses are avoided in the
// loopback cases and the glitch case expects the filtered result.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int TO = 2048;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LO_DUTY = 2;
    localparam int HI_DUTY = 1020;
`else
    localparam int LO_DUTY = 0;
    localparam int HI_DUTY = 1022;
`endif

    logic clk = 1'b0;
    logic rst;

    pwm_capture_if #(.WIDTH(10)) bus ();

    pwm_capture #(
        .WIDTH       (10),
        .SYNC_STAGES (2),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         gen_hi;
    int         gen_per;
    int         gen_cnt;
    bit         glitch_en;
    int         vld_cnt;
    logic [9:0] last_duty;
    logic [9:0] last_per;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the next input level.
    task automatic step();
        @(negedge clk);
        if (bus.duty_vld === 1'b1) begin
            vld_cnt++;
            last_duty = bus.duty_out;
            last_per  = bus.period_out;
            check("duty_le_period", 32'(bus.duty_out <= bus.period_out), 32'd1);
        end
        bus.pwm_in = ((gen_cnt < gen_hi) || (glitch_en && gen_cnt == 600)) ? 1'b1 : 1'b0;
        if (glitch_en && gen_cnt == 600) glitch_en = 1'b0;
        gen_cnt = (gen_cnt + 1 == gen_per) ? 0 : gen_cnt + 1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_gen(input int hi, input int per);
        gen_hi  = hi;
        gen_per = per;
        gen_cnt = 0;
        vld_cnt = 0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.pwm_in = 1'b0;
        glitch_en  = 1'b0;
        last_duty  = 10'd0;
        last_per   = 10'd0;
        set_gen(0, 1024);
        run(4);
        check("reset_duty",   32'(bus.duty_out),   32'd0);
        check("reset_period", 32'(bus.period_out), 32'd0);
        check("reset_vld",    32'(bus.duty_vld),   32'd0);
        check("reset_stuck",  32'(bus.stuck),      32'd0);
        check("reset_lvl",    32'(bus.stuck_lvl),  32'd0);

        // Input held low: stuck exactly TIMEOUT cycles after reset release.
        rst = 1'b0;
        run(TO - 1);
        check("low_pre_stuck", 32'(bus.stuck), 32'd0);
        check("low_pre_vld",   32'(vld_cnt),   32'd0);
        run(1);
        check("low_stuck",  32'(bus.stuck),      32'd1);
        check("low_vld",    32'(bus.duty_vld),   32'd1);
        check("low_duty",   32'(bus.duty_out),   32'd0);
        check("low_period", 32'(bus.period_out), 32'd1023);
        check("low_lvl",    32'(bus.stuck_lvl),  32'd0);
        run(1);
        check("low_vld_pulse", 32'(bus.duty_vld), 32'd0);
        run(3000 - TO - 2);
        check("low_vld_count", 32'(vld_cnt),   32'd1);
        check("low_stuck_hold", 32'(bus.stuck), 32'd1);

        // Loopback duty 300: first rise only arms, later rises report.
        set_gen(301, 1024);
        run(3 * 1024);
        check("d300_count",  32'(vld_cnt),   32'd2);
        check("d300_duty",   32'(last_duty), 32'd300);
        check("d300_period", 32'(last_per),  32'd1023);
        check("d300_stuck",  32'(bus.stuck), 32'd0);

        // Minimum duty.
        set_gen(LO_DUTY + 1, 1024);
        run(3 * 1024);
        check("dlo_count",  32'(vld_cnt),   32'd3);
        check("dlo_duty",   32'(last_duty), 32'(LO_DUTY));
        check("dlo_period", 32'(last_per),  32'd1023);

        // Maximum non-constant duty.
        set_gen(HI_DUTY + 1, 1024);
        run(3 * 1024);
        check("dhi_count",  32'(vld_cnt),   32'd3);
        check("dhi_duty",   32'(last_duty), 32'(HI_DUTY));
        check("dhi_period", 32'(last_per),  32'd1023);

        // Duty 1023 = constant high: stuck high with all-ones report.
        set_gen(1024, 1024);
        run(2100);
        check("d1023_stuck",  32'(bus.stuck),     32'd1);
        check("d1023_lvl",    32'(bus.stuck_lvl), 32'd1);
        check("d1023_duty",   32'(last_duty),     32'd1023);
        check("d1023_period", 32'(last_per),      32'd1023);
        check("d1023_count",  32'(vld_cnt),       32'd2);

        // Recover to duty 500: the fall clears stuck, next rise arms, the one after reports.
        set_gen(501, 1024);
        run(600);
        check("d500_unstuck", 32'(bus.stuck),     32'd0);
        check("d500_lvl",     32'(bus.stuck_lvl), 32'd0);
        check("d500_novld",   32'(vld_cnt),       32'd0);
        run(3 * 1024 - 600);
        check("d500_count",  32'(vld_cnt),   32'd1);
        check("d500_duty",   32'(last_duty), 32'd500);
        check("d500_period", 32'(last_per),  32'd1023);

        // Reset in the middle of a HIGH phase, then a 100/400 waveform.
        set_gen(501, 1024);
        run(100);
        rst = 1'b1;
        set_gen(0, 400);
        run(3);
        check("mid_rst_duty",   32'(bus.duty_out),   32'd0);
        check("mid_rst_period", 32'(bus.period_out), 32'd0);
        check("mid_rst_vld",    32'(bus.duty_vld),   32'd0);
        rst = 1'b0;
        set_gen(100, 400);
        run(800);
        check("rst_count",  32'(vld_cnt),   32'd1);
        check("rst_duty",   32'(last_duty), 32'd99);
        check("rst_period", 32'(last_per),  32'd399);

        // One-cycle glitch during the low phase of a duty-300 waveform.
        set_gen(301, 1024);
        glitch_en = 1'b1;
        run(1044);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch_count",  32'(vld_cnt),   32'd2);
        check("glitch_duty",   32'(last_duty), 32'd300);
        check("glitch_period", 32'(last_per),  32'd1023);
`else
        check("glitch_count",  32'(vld_cnt),   32'd3);
        check("glitch_duty",   32'(last_duty), 32'd0);
        check("glitch_period", 32'(last_per),  32'd423);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
